// File: rtl/fetch_ctrl.sv
// IF-stage fetch sequencer: owns the fetch PC, issues one ibus read at a
// time, and buffers the returned instruction for ID in a 1-entry skid.
module fetch_ctrl #(
    parameter int          XLEN   = 64,
    parameter logic [63:0] PCINIT = 64'h8000_0000
) (
    input  logic            clk,
    input  logic            rst,
    output logic            ireq_valid,
    output logic [XLEN-1:0] ireq_addr,
    input  logic            iresp_addr_ok,
    input  logic            iresp_data_ok,
    input  logic [31:0]     iresp_data,
    input  logic            redirect_valid,
    input  logic [XLEN-1:0] redirect_pc,
    input  logic            id_ready,
    output logic            out_valid,
    output logic [XLEN-1:0] out_pc,
    output logic [31:0]     out_inst,
    output logic [XLEN-1:0] fetch_pc,
    output logic            busy
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        BUSY    = 2'd1,
        DISCARD = 2'd2
    } state_t;

    state_t          state;
    state_t          state_nxt;
    logic [XLEN-1:0] req_addr;
    logic            room;
    logic            accept;
    logic            unused_addr_ok;

    assign unused_addr_ok = iresp_addr_ok;

    assign room   = !out_valid || id_ready;
    assign accept = (state == BUSY) && iresp_data_ok && !redirect_valid;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE: begin
                if (!redirect_valid && room) begin
                    state_nxt = BUSY;
                end
            end
            BUSY: begin
                if (iresp_data_ok) begin
                    state_nxt = IDLE;
                end else if (redirect_valid) begin
                    state_nxt = DISCARD;
                end
            end
            DISCARD: begin
                if (iresp_data_ok) begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // req_addr freezes the in-flight address so a redirect can move
    // fetch_pc without disturbing the bus while the old read drains.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            fetch_pc <= XLEN'(PCINIT);
            req_addr <= '0;
        end else begin
            if (state == IDLE) begin
                req_addr <= fetch_pc;
            end
            if (redirect_valid) begin
                fetch_pc <= {redirect_pc[XLEN-1:2], 2'b00};
            end else if (accept) begin
                fetch_pc <= fetch_pc + XLEN'(4);
            end
        end
    end

    // Redirect flushes the skid even if ID is ready in the same cycle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_valid <= 1'b0;
            out_pc    <= '0;
            out_inst  <= '0;
        end else begin
            if (redirect_valid) begin
                out_valid <= 1'b0;
            end else if (accept) begin
                out_valid <= 1'b1;
                out_pc    <= fetch_pc;
                out_inst  <= iresp_data;
            end else if (id_ready) begin
                out_valid <= 1'b0;
            end
        end
    end

    assign ireq_valid = (state != IDLE);
    assign ireq_addr  = (state != IDLE) ? req_addr : '0;
    assign busy       = (state != IDLE);

endmodule
